// File: rtl/oka_12bit_seq_ctrl.sv
// Sequential 12-bit carry-less Karatsuba multiplier: one 6x6 carry-less core
// reused for the even, odd and cross-term products, recombined into a 23-bit result.

module oka_6bit (
  input  logic [5:0]  a,
  input  logic [5:0]  b,
  output logic [10:0] p
);
  always_comb begin
    p = '0;
    for (int i = 0; i < 6; i++) begin
      if (b[i]) p = p ^ ({5'b0, a} << i);
    end
  end
endmodule

module oka_12bit_seq_ctrl #(
  parameter int N = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a_in,
  input  logic [N-1:0]   b_in,
  input  logic           flush,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-2:0] y_out,
  output logic           busy
);
  localparam int HALF = N / 2;

  if (N != 12) begin : g_n_check
    $error("oka_12bit_seq_ctrl: N must be 12");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MUL_E = 3'd1,
    MUL_O = 3'd2,
    MUL_X = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t              state;
  logic [N-1:0]        a_r, b_r;
  logic [2*HALF-2:0]   pe_r, po_r, core_p;
  logic [2*N-2:0]      y_r;
  logic [HALF-1:0]     ae, ao, be, bo, core_a, core_b;

  // Interleave each 11-bit half product onto the even bit positions.
  function automatic logic [2*(2*HALF-1)-2:0] spr(input logic [2*HALF-2:0] p);
    logic [2*(2*HALF-1)-2:0] r;
    r = '0;
    for (int i = 0; i < 2*HALF-1; i++) r[2*i] = p[i];
    return r;
  endfunction

  // The cross term Pe^Po^Px equals ae*bo ^ ao*be and lands on the odd bits.
  function automatic logic [2*N-2:0] recombine(input logic [2*HALF-2:0] pe,
                                               input logic [2*HALF-2:0] po,
                                               input logic [2*HALF-2:0] px);
    return {2'b00, spr(pe)} ^ {spr(po), 2'b00} ^ {1'b0, spr(pe ^ po ^ px), 1'b0};
  endfunction

  always_comb begin
    for (int i = 0; i < HALF; i++) begin
      ae[i] = a_r[2*i];
      ao[i] = a_r[2*i+1];
      be[i] = b_r[2*i];
      bo[i] = b_r[2*i+1];
    end
  end

  always_comb begin
    core_a = '0;
    core_b = '0;
    case (state)
      MUL_E:   begin core_a = ae;      core_b = be;      end
      MUL_O:   begin core_a = ao;      core_b = bo;      end
      MUL_X:   begin core_a = ae ^ ao; core_b = be ^ bo; end
      default: begin core_a = '0;      core_b = '0;      end
    endcase
  end

  oka_6bit u_core (
    .a (core_a),
    .b (core_b),
    .p (core_p)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      pe_r  <= '0;
      po_r  <= '0;
      y_r   <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a_in;
            b_r   <= b_in;
            state <= MUL_E;
          end
        end
        MUL_E: begin
          pe_r  <= core_p;
          state <= MUL_O;
        end
        MUL_O: begin
          po_r  <= core_p;
          state <= MUL_X;
        end
        MUL_X: begin
          y_r   <= recombine(pe_r, po_r, core_p);
          state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE) && !flush;
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign y_out     = out_valid ? y_r : '0;

endmodule
